updown_cnt_monitor: RTL

//   Reader side of the synchronous up/down counter: samples the counter's q bus
//   and the mode line m every clk, then decodes the step between samples.

---
 rtl/updown_cnt_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/updown_cnt_monitor.sv
// updown_cnt_monitor
//   Checker/decoder that sits beside a synchronous up/down counter in the same
//   clock domain. Every clock it samples the counter's q bus and its mode line,
//   decodes the step from the previous sample, and reports direction, wrap and
//   direction reversals. It also keeps a signed net position, flags steps that
//   disagree with the commanded mode, and latches a sticky fault on any illegal
//   jump.
//
// Ports
//   i_clk      rising-edge clock shared with the counter
//   i_rst      synchronous active-high reset
//   i_q        counter output being monitored (W bits, binary)
//   i_m        counter mode: 1 = up, 0 = down
//   i_clr_err  clears the fault and forces a resync; ignored outside FAULT
//   o_up       pulse: last step was +1
//   o_dn       pulse: last step was -1
//   o_hold     pulse: q did not change between samples
//   o_wrap     pulse: step crossed max->0 (up) or 0->max (down)
//   o_dir_chg  pulse: movement direction reversed vs previous move
//   o_mode_err pulse: step direction disagrees with the previous sample of m
//   o_step_err sticky: illegal jump seen (high while in FAULT)
//   o_pos      signed net steps since last lock (PW bits, wraps silently)
//   o_locked   high while tracking
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | capture first sample, clear position, forget last direction
// TRACK | decode each step, update position and pulse flags
// FAULT | illegal jump seen; pulses off, position frozen until clr_err

module updown_cnt_monitor #(
  parameter int W  = 3,
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [W-1:0]  i_q,
  input  logic          i_m,
  input  logic          i_clr_err,
  output logic          o_up,
  output logic          o_dn,
  output logic          o_hold,
  output logic          o_wrap,
  output logic          o_dir_chg,
  output logic          o_mode_err,
  output logic          o_step_err,
  output logic [PW-1:0] o_pos,
  output logic          o_locked
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [W-1:0] Q_ZERO = '0;
  localparam logic [W-1:0] Q_ONE  = W'(1);
  localparam logic [W-1:0] Q_MAX  = '1;

  state_t        r_state;
  logic [W-1:0]  r_q_d;
  logic          r_m_d;
  logic          r_last_dir;   // 1 = last move was up
  logic          r_dir_vld;

  logic          r_up, r_dn, r_hold, r_wrap, r_dir_chg, r_mode_err, r_step_err;
  logic [PW-1:0] r_pos;
  logic          r_locked;

  state_t        w_state_nx;
  logic [W-1:0]  w_delta;
  logic          w_move;
  logic          w_move_up;
  logic          w_up, w_dn, w_hold, w_wrap, w_dir_chg, w_mode_err, w_step_err;
  logic [PW-1:0] w_pos;
  logic          w_locked;
  logic          w_last_dir;
  logic          w_dir_vld;

  assign w_delta = i_q - r_q_d;

  always_comb begin
    w_state_nx = r_state;
    w_move     = 1'b0;
    w_move_up  = 1'b0;
    w_up       = 1'b0;
    w_dn       = 1'b0;
    w_hold     = 1'b0;
    w_wrap     = 1'b0;
    w_dir_chg  = 1'b0;
    w_mode_err = 1'b0;
    w_step_err = r_step_err;
    w_pos      = r_pos;
    w_locked   = 1'b0;
    w_last_dir = r_last_dir;
    w_dir_vld  = r_dir_vld;

    case (r_state)
      ST_INIT: begin
        w_state_nx = ST_TRACK;
        w_pos      = '0;
        w_dir_vld  = 1'b0;
        w_step_err = 1'b0;
        w_locked   = 1'b1;
      end

      ST_TRACK: begin
        w_locked = 1'b1;
        // +1 is tested before -1 so that a 1-bit counter decodes its only
        // nonzero step as up.
        if (w_delta == Q_ONE) begin
          w_move    = 1'b1;
          w_move_up = 1'b1;
          w_up      = 1'b1;
          w_pos     = r_pos + PW'(1);
          w_wrap    = (r_q_d == Q_MAX);
        end else if (w_delta == Q_MAX) begin
          w_move    = 1'b1;
          w_dn      = 1'b1;
          w_pos     = r_pos - PW'(1);
          w_wrap    = (r_q_d == Q_ZERO);
        end else if (w_delta == Q_ZERO) begin
          w_hold    = 1'b1;
        end else begin
          w_step_err = 1'b1;
          w_locked   = 1'b0;
          w_state_nx = ST_FAULT;
        end

        if (w_move) begin
          w_dir_chg  = r_dir_vld && (w_move_up != r_last_dir);
          w_mode_err = (w_move_up != r_m_d);
          w_last_dir = w_move_up;
          w_dir_vld  = 1'b1;
        end
      end

      ST_FAULT: begin
        w_step_err = 1'b1;
        if (i_clr_err) begin
          w_step_err = 1'b0;
          w_state_nx = ST_INIT;
        end
      end

      default: begin
        w_state_nx = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_INIT;
      r_q_d      <= '0;
      r_m_d      <= 1'b0;
      r_last_dir <= 1'b0;
      r_dir_vld  <= 1'b0;
      r_up       <= 1'b0;
      r_dn       <= 1'b0;
      r_hold     <= 1'b0;
      r_wrap     <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_mode_err <= 1'b0;
      r_step_err <= 1'b0;
      r_pos      <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_q_d      <= i_q;
      r_m_d      <= i_m;
      r_last_dir <= w_last_dir;
      r_dir_vld  <= w_dir_vld;
      r_up       <= w_up;
      r_dn       <= w_dn;
      r_hold     <= w_hold;
      r_wrap     <= w_wrap;
      r_dir_chg  <= w_dir_chg;
      r_mode_err <= w_mode_err;
      r_step_err <= w_step_err;
      r_pos      <= w_pos;
      r_locked   <= w_locked;
    end
  end

  assign o_up       = r_up;
  assign o_dn       = r_dn;
  assign o_hold     = r_hold;
  assign o_wrap     = r_wrap;
  assign o_dir_chg  = r_dir_chg;
  assign o_mode_err = r_mode_err;
  assign o_step_err = r_step_err;
  assign o_pos      = r_pos;
  assign o_locked   = r_locked;

endmodule
